video_in_write: RTL
===================

VIDEO_IN_WRITE -- requirements
Module: video_in_write

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of 32-bit words buffered between packer and bus master (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1, system clock at 100 MHz, all logic on rising edge.
REQ-003 The block SHALL have port RST, input, 1; there is one clock, and reset is synchronous and active-high.
REQ-004 The block SHALL have port wb_reg_data, input, 32, frame base byte address in RAM.
REQ-005 The block SHALL have port wb_reg_ctr, input, 32, control; bit0 = capture enable, other bits ignored.
REQ-006 The block SHALL have ports frame_valid, line_valid, pix_en, input, 1 each, video qualifiers synchronous to clk.
REQ-007 The block SHALL have port pixel_in, input, 8, pixel byte, valid when frame_valid&line_valid&pix_en.
REQ-008 The block SHALL have port interrupt, output, 1, one-cycle end-of-frame pulse.
REQ-009 The block SHALL have port overflow, output, 1, sticky word-drop flag.
REQ-010 The block SHALL have Wishbone master outputs p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O (1 each), p_wb_SEL_O (4), p_wb_ADR_O (32), p_wb_DAT_O (32), and input p_wb_ACK_I (1).

Function
REQ-011 FSM states SHALL be IDLE, WAIT_SOF, CAPTURE, FLUSH.
REQ-012 IDLE -> WAIT_SOF when wb_reg_ctr[0]=1; WAIT_SOF -> IDLE if enable drops.
REQ-013 WAIT_SOF -> CAPTURE on frame_valid rising edge (0 in previous cycle, 1 now); same cycle latch wb_reg_data as write address, clear byte counter.
REQ-014 A frame already in progress when enable is set SHALL be ignored; capture starts only at a rising edge.
REQ-015 In CAPTURE, each accepted pixel SHALL be packed little-endian: 1st pixel to bits[7:0], 4th to bits[31:24].
REQ-016 On the 4th byte, the word SHALL be pushed into the word FIFO in the same cycle; packer restarts at byte 0.
REQ-017 If the word FIFO is full at push, the word SHALL be dropped, overflow set to 1, and the address still advances by 4 for that word.
REQ-018 CAPTURE -> FLUSH on frame_valid falling edge; a partial word (1-3 bytes) SHALL be pushed with unfilled upper bytes zero.
REQ-019 Enable dropping during CAPTURE SHALL NOT abort the frame; it takes effect after FLUSH.
REQ-020 FLUSH -> WAIT_SOF (enable=1) or IDLE (enable=0) when FIFO empty and no bus cycle open; interrupt=1 for exactly that cycle.
REQ-021 A frame_valid rising edge during FLUSH SHALL be ignored (that frame skipped).
REQ-022 Bus master: when FIFO non-empty and no cycle open, next cycle STB=CYC=1, WE=1, SEL=4'hF, ADR=word address, DAT=FIFO head.
REQ-023 STB/CYC/ADR/DAT SHALL hold stable until p_wb_ACK_I=1; on ACK pop FIFO, address+=4 (mod 2^32), STB=CYC=0 next cycle for at least one cycle.
REQ-024 p_wb_LOCK_O SHALL be constant 0; ACK while no cycle open SHALL be ignored.
REQ-025 Push and pop in the same cycle SHALL leave occupancy unchanged and be legal when full.
REQ-026 Bus address counter SHALL be separate from the push-side counter; dropped words skip their address slot in both.
REQ-027 overflow SHALL clear only on RST or at a WAIT_SOF -> CAPTURE transition.

Reset
REQ-028 On RST=1 at a clock edge: state IDLE, FIFO empty, packer cleared, address counters 0, interrupt=0, overflow=0, STB=CYC=WE=0, SEL=0, ADR=0, DAT=0.
REQ-029 RST mid-bus-cycle SHALL drop STB/CYC the next edge; the outstanding word is discarded.

Structure
REQ-030 Package video_pkg SHALL hold the FSM state enum, PIXEL_W=8, WORD_W=32, BYTES_PER_WORD=4.
REQ-031 The word FIFO SHALL be a sub-module video_in_wfifo (sync, FIFO_DEPTH x 32, full/empty, push/pop).

Verification
REQ-032 Base 0x1000_0000, 2 lines x 8 pixels 0x00..0x0F, ACK 1 cycle after STB -> 4 writes to 0x1000_0000..0x1000_000C, first DAT 0x0302_0100, one interrupt.
REQ-033 10-pixel frame -> 3 writes, third DAT 0x0000_0908, interrupt after third ACK.
REQ-034 ACK held off 40 cycles, 64-pixel frame, FIFO_DEPTH 8 -> overflow=1, address gaps at dropped words, interrupt still fires.
REQ-035 Enable set mid-frame -> no writes until next frame_valid rise; enable cleared mid-frame -> frame completes, then IDLE.
REQ-036 RST during open bus cycle -> STB/CYC=0 next cycle, all outputs at reset values, no interrupt.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video capture write path.
package video_pkg;

    localparam int PIXEL_W        = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
    // Dropped-word count carried with each stored word so the bus side can skip address slots.
    localparam int SKIP_W         = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOF,
        CAPTURE,
        FLUSH
    } state_t;

    function automatic logic [WORD_W-1:0] insert_byte(
        input logic [WORD_W-1:0]     word,
        input logic [BYTE_IDX_W-1:0] idx,
        input logic [PIXEL_W-1:0]    px
    );
        logic [WORD_W-1:0] w;
        w = word;
        w[idx*PIXEL_W +: PIXEL_W] = px;
        return w;
    endfunction

endpackage

// File: rtl/video_in_wfifo.sv
// Synchronous word FIFO between the pixel packer and the bus master.
module video_in_wfifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

    // A push while full is accepted only when a pop frees the slot in the same cycle.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/video_in_write.sv
// Captures one video frame, packs pixels into 32-bit words and writes them to RAM over Wishbone.
module video_in_write
    import video_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] wb_reg_data,
    input  logic [31:0] wb_reg_ctr,
    input  logic        frame_valid,
    input  logic        line_valid,
    input  logic        pix_en,
    input  logic [7:0]  pixel_in,
    output logic        interrupt,
    output logic        overflow,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I
);

    localparam int FIFO_W = WORD_W + SKIP_W;

    state_t                state_q, state_d;
    logic                  fv_prev_q;
    logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [31:0]           push_addr_q, push_addr_d;
    logic [31:0]           gap_base_q, gap_base_d;
    logic [31:0]           bus_addr_q, bus_addr_d;
    logic                  overflow_q, overflow_d;
    logic                  interrupt_q, interrupt_d;
    logic                  stb_q, stb_d;
    logic [31:0]           adr_q, adr_d;
    logic [31:0]           dat_q, dat_d;

    logic                  enable, sof, eof, px_ok;
    logic                  push_req;
    logic [WORD_W-1:0]     push_word, word_fill;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0]     fifo_wdata, fifo_head;
    logic                  ctr_unused;

    assign enable     = wb_reg_ctr[0];
    assign ctr_unused = ^wb_reg_ctr[31:1];
    assign sof        = frame_valid & ~fv_prev_q;
    assign eof        = ~frame_valid & fv_prev_q;
    assign px_ok      = frame_valid & line_valid & pix_en;
    assign word_fill  = insert_byte(word_q, byte_cnt_q, pixel_in);

    video_in_wfifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_wfifo (
        .clk       (clk),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        push_addr_d = push_addr_q;
        gap_base_d  = gap_base_q;
        bus_addr_d  = bus_addr_q;
        overflow_d  = overflow_q;
        interrupt_d = 1'b0;
        stb_d       = stb_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        push_req    = 1'b0;
        push_word   = '0;
        fifo_push   = 1'b0;
        fifo_wdata  = '0;
        fifo_pop    = stb_q & p_wb_ACK_I;

        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sof) begin
                    state_d     = CAPTURE;
                    push_addr_d = wb_reg_data;
                    gap_base_d  = wb_reg_data;
                    bus_addr_d  = wb_reg_data;
                    byte_cnt_d  = '0;
                    word_d      = '0;
                    overflow_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (eof) begin
                    state_d    = FLUSH;
                    push_req   = (byte_cnt_q != '0);
                    push_word  = word_q;
                    byte_cnt_d = '0;
                    word_d     = '0;
                end else if (px_ok) begin
                    if (byte_cnt_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
                        push_req   = 1'b1;
                        push_word  = word_fill;
                        byte_cnt_d = '0;
                        word_d     = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        word_d     = word_fill;
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty && !stb_q) begin
                    state_d     = enable ? WAIT_SOF : IDLE;
                    interrupt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every word consumes an address slot; stored words remember how many slots were dropped before them.
        if (push_req) begin
            push_addr_d = push_addr_q + 32'd4;
            if (fifo_full && !fifo_pop) begin
                overflow_d = 1'b1;
            end else begin
                fifo_push  = 1'b1;
                fifo_wdata = {SKIP_W'((push_addr_q - gap_base_q) >> 2), push_word};
                gap_base_d = push_addr_q + 32'd4;
            end
        end

        if (stb_q) begin
            if (p_wb_ACK_I) begin
                stb_d      = 1'b0;
                bus_addr_d = adr_q + 32'd4;
            end
        end else if (!fifo_empty) begin
            stb_d = 1'b1;
            adr_d = bus_addr_q + {{(30-SKIP_W){1'b0}}, fifo_head[FIFO_W-1:WORD_W], 2'b00};
            dat_d = fifo_head[WORD_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            fv_prev_q   <= 1'b0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            push_addr_q <= '0;
            gap_base_q  <= '0;
            bus_addr_q  <= '0;
            overflow_q  <= 1'b0;
            interrupt_q <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            fv_prev_q   <= frame_valid;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            push_addr_q <= push_addr_d;
            gap_base_q  <= gap_base_d;
            bus_addr_q  <= bus_addr_d;
            overflow_q  <= overflow_d;
            interrupt_q <= interrupt_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign interrupt   = interrupt_q;
    assign overflow    = overflow_q;
    assign p_wb_STB_O  = stb_q;
    assign p_wb_CYC_O  = stb_q;
    assign p_wb_WE_O   = stb_q;
    assign p_wb_LOCK_O = 1'b0;
    assign p_wb_SEL_O  = {4{stb_q}};
    assign p_wb_ADR_O  = adr_q;
    assign p_wb_DAT_O  = dat_q;

endmodule
